// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Memory-access stage of the 16-bit pipeline. It takes load/store requests
//   from the EX/MEM register, drives the data memory directly and buffers load
//   results (data + destination tag) in a 2-entry FIFO toward write-back.
//
//   Optional feature macro: MEM_ACCESS_STATS_EN adds saturating 16-bit
//   load_count / store_count outputs.
//
// Handshakes (valid/ready): a transfer happens in a cycle where both valid
//   and ready are high at the rising clock edge. The producer holds valid and
//   its payload until accepted. Request side: req_valid/req_ready. Result
//   side: wb_valid/wb_ready (a pop).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_we, req_addr,         1 = store / 0 = load, word address,
//   req_wdata, req_tag        store data, load destination register
//   dm_address, dm_data_in,   data-memory address / write data /
//   dm_write_en               write enable (combinational from the request)
//   dm_data_out               registered read data from the data memory
//   wb_valid/wb_ready         result FIFO head handshake
//   wb_data, wb_tag           result FIFO head payload
//   load_count, store_count   (MEM_ACCESS_STATS_EN only) accepted op counters
// -----------------------------------------------------------------------------
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

module mem_access_unit #(
  parameter int DW    = `DSIZE,
  parameter int AW    = `MEM_SPACE,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [DW-1:0]    req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic [AW-1:0]    dm_address,
  output logic [DW-1:0]    dm_data_in,
  output logic             dm_write_en,
  input  logic [DW-1:0]    dm_data_out,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [DW-1:0]    wb_data,
  output logic [TAG_W-1:0] wb_tag
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [15:0]      load_count,
  output logic [15:0]      store_count
`endif
);

  logic             accept;
  logic             load_acc;
  logic             store_acc;
  logic             push;
  logic             pop;

  logic             inflight;
  logic [TAG_W-1:0] tag_q;

  logic [DW-1:0]    fifo_data [2];
  logic [TAG_W-1:0] fifo_tag  [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  assign pop      = wb_valid && wb_ready;
  // A load accepted last cycle always lands in the FIFO this cycle.
  assign push     = inflight;

  // Slots are reserved for the in-flight load as well as buffered results;
  // stores obey the same rule so they stay ordered behind pending loads.
  // count + inflight never exceeds 2, so the 2-bit sum cannot wrap.
  assign req_ready = ((count + {1'b0, inflight}) < 2'd2) || pop;

  assign accept    = req_valid && req_ready;
  assign load_acc  = accept && !req_we;
  assign store_acc = accept && req_we;

  assign dm_address  = req_addr;
  assign dm_data_in  = req_wdata;
  // Gated by rst so no write can slip into memory while the stage is reset.
  assign dm_write_en = store_acc && !rst;

  assign wb_valid = (count != 2'd0);
  assign wb_data  = fifo_data[rd_ptr];
  assign wb_tag   = fifo_tag[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight     <= 1'b0;
      tag_q        <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_tag[0]  <= '0;
      fifo_tag[1]  <= '0;
    end else begin
      inflight <= load_acc;
      if (load_acc) begin
        tag_q <= req_tag;
      end
      if (push) begin
        fifo_data[wr_ptr] <= dm_data_out;
        fifo_tag[wr_ptr]  <= tag_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifndef SYNTHESIS
  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (push && !pop) |-> (count < 2'd2))
    else $error("mem_access_unit: result push with no free FIFO entry");
`endif

`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_count  <= 16'd0;
      store_count <= 16'd0;
    end else begin
      if (load_acc && (load_count != 16'hFFFF)) begin
        load_count <= load_count + 16'd1;
      end
      if (store_acc && (store_count != 16'hFFFF)) begin
        store_count <= store_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a behavioural registered data
//   memory. Expected results come from hand-chosen memory contents:
//   mem[i] = 0xA500 | i, except mem[5] = 0x1234.
// -----------------------------------------------------------------------------
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

module tb_mem_access_unit;

  localparam int DW    = `DSIZE;
  localparam int AW    = `MEM_SPACE;
  localparam int TAG_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_wdata;
  logic [TAG_W-1:0] req_tag;
  logic [AW-1:0]    dm_address;
  logic [DW-1:0]    dm_data_in;
  logic             dm_write_en;
  logic [DW-1:0]    dm_data_out;
  logic             wb_valid;
  logic             wb_ready;
  logic [DW-1:0]    wb_data;
  logic [TAG_W-1:0] wb_tag;
`ifdef MEM_ACCESS_STATS_EN
  logic [15:0]      load_count;
  logic [15:0]      store_count;
`endif

  mem_access_unit #(.DW(DW), .AW(AW), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_tag     (req_tag),
    .dm_address  (dm_address),
    .dm_data_in  (dm_data_in),
    .dm_write_en (dm_write_en),
    .dm_data_out (dm_data_out),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_tag      (wb_tag)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .load_count  (load_count),
    .store_count (store_count)
`endif
  );

  // ---------------- data memory model (registered read) ----------------
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (dm_write_en) mem[dm_address] <= dm_data_in;
    dm_data_out <= mem[dm_address];
  end

  // ---------------- scoreboard ----------------
  logic [TAG_W+DW-1:0] exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_tag   = '0;
  endtask

  task automatic drive_load(input int addr, input int tag);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = AW'(addr);
    req_wdata = '0;
    req_tag   = TAG_W'(tag);
  endtask

  task automatic drive_store(input int addr, input int data);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = AW'(addr);
    req_wdata = DW'(data);
    req_tag   = '0;
  endtask

  // Idle the request side and compare every result against exp_q until it
  // empties; a bounded wait so a stuck DUT still reaches the summary.
  task automatic drain(input string name);
    logic [TAG_W+DW-1:0] e;
    drive_idle();
    wb_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
      settle();
      if (wb_valid) begin
        e = exp_q.pop_front();
        chk({name, "_data"}, 32'(wb_data), 32'(e[DW-1:0]));
        chk({name, "_tag"}, 32'(wb_tag), 32'(e[TAG_W+DW-1:DW]));
      end
      tick();
    end
    chk({name, "_all_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(16'hA500 | 16'(i & 255));
    mem[5] = DW'(16'h1234);
    drive_idle();
    wb_ready = 1'b1;

    // Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom_range(0, 255));
      req_wdata = DW'($urandom_range(0, 65535));
      req_tag   = TAG_W'($urandom_range(0, 15));
      wb_ready  = 1'($urandom_range(0, 1));
      settle();
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_dm_we", 32'(dm_write_en), 32'd0);
    end
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_wb_tag", 32'(wb_tag), 32'd0);
    tick();
    rst = 1'b0;
    drive_idle();
    wb_ready = 1'b1;
    tick();

    // Single load: addr 5 tag 3 in cycle k -> result in k+2.
    drive_load(5, 3);
    settle();
    chk("ld_ready", 32'(req_ready), 32'd1);
    chk("ld_dm_we", 32'(dm_write_en), 32'd0);
    chk("ld_dm_addr", 32'(dm_address), 32'd5);
    tick();
    drive_idle();
    settle();
    chk("ld_k1_valid", 32'(wb_valid), 32'd0);
    tick();
    settle();
    chk("ld_k2_valid", 32'(wb_valid), 32'd1);
    chk("ld_k2_data", 32'(wb_data), 32'h1234);
    chk("ld_k2_tag", 32'(wb_tag), 32'd3);
    tick();
    settle();
    chk("ld_popped", 32'(wb_valid), 32'd0);

    // Store 0x00AA to 7 in k, load 7 in k+1 -> 0x00AA in k+3.
    drive_store(7, 16'h00AA);
    settle();
    chk("st_dm_we", 32'(dm_write_en), 32'd1);
    chk("st_dm_addr", 32'(dm_address), 32'd7);
    chk("st_dm_data", 32'(dm_data_in), 32'h00AA);
    tick();
    drive_load(7, 9);
    settle();
    chk("stld_ready", 32'(req_ready), 32'd1);
    chk("stld_k1_valid", 32'(wb_valid), 32'd0);
    tick();
    drive_idle();
    settle();
    chk("stld_k2_valid", 32'(wb_valid), 32'd0);
    tick();
    settle();
    chk("stld_k3_valid", 32'(wb_valid), 32'd1);
    chk("stld_k3_data", 32'(wb_data), 32'h00AA);
    chk("stld_k3_tag", 32'(wb_tag), 32'd9);
    tick();

    // Backpressure: three loads offered with wb_ready low.
    wb_ready = 1'b0;
    drive_load(10, 1);
    settle();
    chk("bp_c0_ready", 32'(req_ready), 32'd1);
    tick();
    drive_load(11, 2);
    settle();
    chk("bp_c1_ready", 32'(req_ready), 32'd1);
    tick();
    drive_load(12, 4);
    settle();
    chk("bp_c2_ready", 32'(req_ready), 32'd0);
    tick();
    settle();
    chk("bp_c3_ready", 32'(req_ready), 32'd0);
    chk("bp_c3_valid", 32'(wb_valid), 32'd1);
    chk("bp_c3_data", 32'(wb_data), 32'hA50A);
    chk("bp_c3_tag", 32'(wb_tag), 32'd1);
    chk("bp_c3_dm_we", 32'(dm_write_en), 32'd0);
    tick();
    wb_ready = 1'b1;
    settle();
    chk("bp_c4_ready", 32'(req_ready), 32'd1);
    chk("bp_c4_data", 32'(wb_data), 32'hA50A);
    tick();
    drive_idle();
    settle();
    chk("bp_c5_data", 32'(wb_data), 32'hA50B);
    chk("bp_c5_tag", 32'(wb_tag), 32'd2);
    tick();
    settle();
    chk("bp_c6_valid", 32'(wb_valid), 32'd1);
    chk("bp_c6_data", 32'(wb_data), 32'hA50C);
    chk("bp_c6_tag", 32'(wb_tag), 32'd4);
    tick();
    settle();
    chk("bp_c7_valid", 32'(wb_valid), 32'd0);

    // Streaming: 8 back-to-back loads, results two cycles behind.
    for (int i = 0; i < 10; i++) begin
      logic [TAG_W+DW-1:0] e;
      if (i < 8) drive_load(20 + i, i);
      else drive_idle();
      settle();
      if (i < 8) begin
        chk("str_ready", 32'(req_ready), 32'd1);
        exp_q.push_back({TAG_W'(i), DW'(16'hA500 | 16'(20 + i))});
      end
      if (i >= 2) begin
        chk("str_valid", 32'(wb_valid), 32'd1);
        e = exp_q.pop_front();
        chk("str_data", 32'(wb_data), 32'(e[DW-1:0]));
        chk("str_tag", 32'(wb_tag), 32'(e[TAG_W+DW-1:DW]));
      end
      tick();
    end
    settle();
    chk("str_end_valid", 32'(wb_valid), 32'd0);

    // Reset mid-flight with 2 results buffered.
    wb_ready = 1'b0;
    drive_load(30, 5);
    tick();
    drive_load(31, 6);
    tick();
    drive_idle();
    tick();
    settle();
    chk("mr_buffered", 32'(wb_valid), 32'd1);
    rst = 1'b1;
    drive_store(40, 16'hDEAD);
    settle();
    chk("mr_valid_drop", 32'(wb_valid), 32'd0);
    chk("mr_ready", 32'(req_ready), 32'd1);
    chk("mr_dm_we", 32'(dm_write_en), 32'd0);
    tick();
    rst = 1'b0;
    drive_idle();
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("mr_no_stale", 32'(wb_valid), 32'd0);
      tick();
    end

    // Resume, plus 2 stores and 2 loads reading them back.
    drive_load(5, 7);
    exp_q.push_back({TAG_W'(7), DW'(16'h1234)});
    tick();
    drain("resume");
    drive_store(40, 16'hBEEF);
    tick();
    drive_store(41, 16'hCAFE);
    tick();
    drive_load(40, 1);
    exp_q.push_back({TAG_W'(1), DW'(16'hBEEF)});
    tick();
    drive_load(41, 2);
    exp_q.push_back({TAG_W'(2), DW'(16'hCAFE)});
    tick();
    drain("rdback");
`ifdef MEM_ACCESS_STATS_EN
    chk("stats_loads", 32'(load_count), 32'd3);
    chk("stats_stores", 32'(store_count), 32'd2);
`endif

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the 16-bit pipeline, sitting directly upstream of the data memory. It accepts load and store requests from the EX/MEM pipeline register with a valid/ready handshake. It drives the data memory's address, write-data and write-enable inputs, and captures the memory's registered read data one cycle later. Load results, tagged with their destination register, are buffered in a 2-entry result FIFO toward write-back, which can apply backpressure.

## Interface
- DW, default `DSIZE (16): data width.
- AW, default `MEM_SPACE: memory address width.
- TAG_W, default 4: destination-register tag width.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept the request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  AW  word address.
- req_wdata  input  DW  store data.
- req_tag  input  TAG_W  load destination register.
- dm_address  output  AW  to data memory address.
- dm_data_in  output  DW  to data memory write data.
- dm_write_en  output  1  to data memory write enable, active-high.
- dm_data_out  input  DW  registered read data from data memory.
- wb_valid  output  1  FIFO head holds a load result.
- wb_ready  input  1  write-back consumes the head this cycle.
- wb_data  output  DW  head load data.
- wb_tag  output  TAG_W  head destination tag.

## Operation
- A request is accepted when req_valid && req_ready.
- dm_address = req_addr and dm_data_in = req_wdata, combinationally, every cycle.
- dm_write_en = req_valid && req_ready && req_we, combinationally.
- Store: the memory is written at the end of the accept cycle. A store produces no result entry.
- Load: on accept, inflight is set to 1 and req_tag is captured in tag_q. In the next cycle, dm_data_out together with tag_q is pushed into the FIFO, and inflight clears unless another load is accepted in that same cycle.
- FIFO: 2 entries, with a read pointer, a write pointer (both wrap modulo 2) and a count from 0 to 2. The head drives wb_data and wb_tag. wb_valid = (count != 0).
- A pop occurs when wb_valid && wb_ready. A push and a pop in the same cycle leave count unchanged.
- req_ready = (count + inflight < 2) || (wb_valid && wb_ready). The same rule applies to stores and loads, so a store never overtakes an older load's write-back slot.
- The FIFO never overflows. Any push without room is an RTL bug and is flagged by a simulation assertion.
- Read-during-write to the same address in one cycle is not possible, because only one request is accepted per cycle.

## Timing
- Reset values: req_ready 1, wb_valid 0, wb_data 0, wb_tag 0, count 0, inflight 0, both pointers 0. dm_write_en is 0 whenever no store is accepted.
- Load latency: a load accepted in cycle k has wb_valid high in cycle k+2.
- Throughput: with wb_ready held high, one load or store is accepted per cycle.
- Store then load to the same address in cycle k+1 returns the stored value.
- With wb_ready low, at most 2 loads are outstanding (FIFO entries plus the in-flight load). req_ready drops once that limit is reached.
- When rst is asserted mid-operation, in-flight and buffered results are discarded immediately and dm_write_en is forced to 0. Operation resumes on the first rising edge after deassertion.

## Configuration
- MEM_ACCESS_STATS_EN: when defined, adds output ports load_count[15:0] and store_count[15:0].
  - Each counter increments on an accepted load or store respectively and saturates at 0xFFFF.
  - Both counters reset to 0.
- When the macro is undefined, these ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Reset: assert rst for 3 cycles with random inputs -> wb_valid 0, req_ready 1, dm_write_en 0 throughout.
- Single load: memory[5] = 0x1234, load addr 5 with tag 3 accepted in cycle k -> wb_valid=1, wb_data=0x1234, wb_tag=3 in cycle k+2.
- Store-then-load: store 0x00AA to addr 7 in cycle k, load addr 7 in cycle k+1 -> wb_data=0x00AA in cycle k+3.
- Backpressure: wb_ready=0, three loads offered back-to-back -> exactly 2 accepted and req_ready=0. Raise wb_ready -> results appear in order, then the third load is accepted.
- Streaming: 8 consecutive loads with wb_ready=1 -> req_ready never drops and 8 results appear in order, with tags preserved.
- Reset mid-flight: assert rst with 2 results buffered -> wb_valid falls immediately and no stale result appears after release. With MEM_ACCESS_STATS_EN defined: 3 loads and 2 stores -> load_count=3, store_count=2.
